cic_ctrl: RTL and testbench
===========================

Name: cic_ctrl

Overview:
Sequencer for the CIC decimator datapath. It generates the PDM bit-rate clock enable and the decimation strobe from the single system clock, and holds the CIC in reset during start-up. It discards the CIC settling outputs and delivers decimated samples over a valid/ready handshake with overrun detection. It sits between the PDM front end and the downstream sample consumer, and owns the CIC's reset and timing.

Parameters:
CLK_DIV, 8, system clocks per PDM bit (pdm_ce period); legal range is 2 or more.
RW, 8, width of the decimation-ratio field.
DEF_RATIO, 64, decimation ratio after reset.
N_STAGES, 3, CIC order; the number of dec_stb outputs discarded after (re)start.
FLUSH_CYC, 4, pdm_ce pulses for which cic_rst is held in FLUSH.
OW, 24, CIC output / sample width.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  run enable; level sensitive.
ratio_in  in  RW  new decimation ratio.
ratio_ld  in  1  one-cycle pulse; loads ratio_in into the shadow register.
cic_out  in  OW  CIC decimated output.
cic_rst  out  1  active-high synchronous reset to the CIC.
pdm_ce  out  1  one-cycle PDM sample enable.
dec_stb  out  1  one-cycle decimation strobe to the CIC.
smp_data  out  OW  captured sample.
smp_valid  out  1  smp_data is valid.
smp_ready  in  1  consumer accepts smp_data.
overrun  out  1  sticky flag: an unconsumed sample was overwritten.
ov_clr  in  1  clears overrun.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cic_rst=1, ratio=shadow=DEF_RATIO, all other outputs and counters 0.
- States: IDLE -> FLUSH -> SETTLE -> RUN.
  - IDLE->FLUSH when en=1.
  - FLUSH->SETTLE after FLUSH_CYC pdm_ce pulses.
  - SETTLE->RUN after N_STAGES dec_stb pulses.
  - RUN->SETTLE on a ratio change being applied.
  - Any state ->IDLE on en=0, taking effect next cycle and overriding every other event.
- Divider: div_cnt runs 0..CLK_DIV-1 in all states except IDLE. pdm_ce=1 in the cycle div_cnt==CLK_DIV-1. In IDLE, div_cnt=0 and pdm_ce=0.
- Decimation counter: dec_cnt counts pdm_ce pulses 0..ratio-1 in SETTLE and RUN. dec_stb=pdm_ce AND dec_cnt==ratio-1, then dec_cnt wraps to 0. dec_cnt is held at 0 in IDLE and FLUSH.
- cic_rst=1 in IDLE and FLUSH, 0 otherwise.
- Ratio handling:
  - ratio_ld writes the shadow register; values below 2 are clamped to 2.
  - In IDLE or FLUSH the shadow is applied immediately, in the next cycle.
  - In SETTLE or RUN the shadow is applied in the dec_stb cycle when shadow differs from ratio.
  - An application in RUN moves to SETTLE and restarts the settle count; an application in SETTLE restarts the settle count.
  - ratio_ld coincident with dec_stb: the new value is applied at that same strobe.
- Capture (RUN only):
  - The cycle after dec_stb, cic_out is registered into smp_data and smp_valid=1. Total latency is dec_stb at T, smp_valid high from T+2.
  - Dec_stb cycles in SETTLE, and the dec_stb that triggers the RUN->SETTLE transition, capture nothing.
- Handshake:
  - smp_valid clears when smp_valid and smp_ready are both 1 and no capture occurs in that cycle.
  - If a capture occurs while smp_valid=1 and smp_ready=0: new data overwrites, smp_valid stays 1, overrun=1.
  - Capture coincident with an accept (smp_ready=1): no overrun, smp_valid stays 1 with the new data.
  - overrun holds until an ov_clr cycle. If ov_clr coincides with a new overrun, set wins.
- en=0 mid-operation: smp_valid cleared, smp_data held, overrun held, dec_cnt and div_cnt zeroed next cycle.
- busy=1 when state is not IDLE.

Decomposition:
- Shared package cic_pkg holds:
  - state encoding constants (IDLE=0, FLUSH=1, SETTLE=2, RUN=3);
  - defaults DEF_RATIO, OW and N_STAGES;
  - MIN_RATIO=2.
- One sub-module, cic_ce_gen: the divider plus decimation counter producing pdm_ce and dec_stb, with ratio and enable inputs.
- The FSM, capture and handshake logic stay in cic_ctrl.

Test Plan:
- CLK_DIV=4, ratio_ld 8 in IDLE, en=1 -> cic_rst high for 16 cycles; pdm_ce every 4 cycles; dec_stb every 32 cycles; first 3 strobes produce no smp_valid; 4th strobe at T gives smp_valid at T+2 with smp_data=cic_out sampled at T+1.
- RUN with smp_ready=0 for two strobes -> overrun=1 after the 2nd capture, smp_data = 2nd value; ov_clr pulse -> overrun=0.
- ratio_ld 16 mid-RUN -> the old period of 32 is kept until the next dec_stb, then the period becomes 64 cycles; 3 discarded strobes before valid resumes.
- ratio_ld 0 -> the effective period equals a ratio of 2 (dec_stb every 8 cycles).
- en=0 in RUN with smp_valid=1 -> next cycle state=IDLE, smp_valid=0, cic_rst=1, pdm_ce=0, busy=0.
- rst asserted low mid-RUN (asynchronously, between clock edges) -> outputs take their reset values immediately; ratio returns to 64.

Source files
------------

// File: rtl/cic_pkg.sv
`default_nettype none
// cic_pkg: shared state encoding and default configuration for the CIC sequencer.
// Rev 1.0
package cic_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int CIC_DEF_RATIO = 64;
    localparam int CIC_OW        = 24;
    localparam int CIC_N_STAGES  = 3;
    localparam int CIC_MIN_RATIO = 2;

endpackage
`default_nettype wire

// File: rtl/cic_ctrl_if.sv
`default_nettype none
// cic_ctrl_if: control, CIC timing and sample handshake bundle of the CIC sequencer.
// Rev 1.0
interface cic_ctrl_if #(
    parameter int RW = 8,
    parameter int OW = cic_pkg::CIC_OW
);
    logic          en;
    logic [RW-1:0] ratio_in;
    logic          ratio_ld;
    logic [OW-1:0] cic_out;
    logic          cic_rst;
    logic          pdm_ce;
    logic          dec_stb;
    logic [OW-1:0] smp_data;
    logic          smp_valid;
    logic          smp_ready;
    logic          overrun;
    logic          ov_clr;
    logic          busy;

    modport slave (
        input  en, ratio_in, ratio_ld, cic_out, smp_ready, ov_clr,
        output cic_rst, pdm_ce, dec_stb, smp_data, smp_valid, overrun, busy
    );

    modport master (
        output en, ratio_in, ratio_ld, cic_out, smp_ready, ov_clr,
        input  cic_rst, pdm_ce, dec_stb, smp_data, smp_valid, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/cic_ce_gen.sv
`default_nettype none
// cic_ce_gen: PDM bit-rate divider and decimation counter producing pdm_ce and dec_stb.
// Rev 1.0
module cic_ce_gen #(
    parameter int CLK_DIV = 8,
    parameter int RW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_i,
    input  logic          dec_run_i,
    input  logic          clr_i,
    input  logic [RW-1:0] ratio_i,
    output logic          pdm_ce_o,
    output logic          dec_stb_o
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [RW-1:0] dec_q, dec_d;
    logic          div_wrap;
    logic          dec_wrap;

    assign div_wrap  = (div_q == DW'(CLK_DIV - 1));
    // >= keeps the counter bounded even if the ratio were ever lowered mid-count
    assign dec_wrap  = (dec_q >= (ratio_i - RW'(1)));
    assign pdm_ce_o  = run_i && div_wrap;
    assign dec_stb_o = dec_run_i && pdm_ce_o && dec_wrap;

    always_comb begin
        div_d = div_wrap ? '0 : div_q + DW'(1);
        if (clr_i || !run_i) begin
            div_d = '0;
        end
        dec_d = dec_q;
        if (clr_i || !dec_run_i) begin
            dec_d = '0;
        end else if (pdm_ce_o) begin
            dec_d = dec_wrap ? '0 : dec_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            dec_q <= '0;
        end else begin
            div_q <= div_d;
            dec_q <= dec_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cic_ctrl.sv
`default_nettype none
// cic_ctrl: CIC decimator sequencer -- start-up flush, settle discard, ratio shadowing
// and valid/ready sample delivery with sticky overrun.  Rev 1.0
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int RW        = 8,
    parameter int DEF_RATIO = CIC_DEF_RATIO,
    parameter int N_STAGES  = CIC_N_STAGES,
    parameter int FLUSH_CYC = 4,
    parameter int OW        = CIC_OW
) (
    input  logic       clk,
    input  logic       rst_n,
    cic_ctrl_if.slave  ctl
);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int SW = $clog2(N_STAGES + 1);

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [RW-1:0] ratio_q, ratio_d;
    logic [RW-1:0] shadow_q;
    logic          cap_q, cap_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          pdm_ce;
    logic          dec_stb;
    logic          in_reset;
    logic [RW-1:0] ld_val;
    logic [RW-1:0] shadow_nxt;
    logic          apply;
    logic          capture;
    logic          ovr_set;

    assign in_reset   = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign ld_val     = (ctl.ratio_in < RW'(CIC_MIN_RATIO)) ? RW'(CIC_MIN_RATIO) : ctl.ratio_in;
    // A load in the strobe cycle itself must be seen by that strobe's compare
    assign shadow_nxt = ctl.ratio_ld ? ld_val : shadow_q;
    assign apply      = dec_stb && (shadow_nxt != ratio_q);
    assign capture    = cap_q && ctl.en;
    assign ovr_set    = capture && valid_q && !ctl.smp_ready;

    cic_ce_gen #(
        .CLK_DIV (CLK_DIV),
        .RW      (RW)
    ) u_ce_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q != ST_IDLE),
        .dec_run_i (!in_reset),
        .clr_i     (!ctl.en),
        .ratio_i   (ratio_q),
        .pdm_ce_o  (pdm_ce),
        .dec_stb_o (dec_stb)
    );

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                flush_d = '0;
                if (ctl.en) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (pdm_ce) begin
                    if (flush_q == FW'(FLUSH_CYC - 1)) begin
                        state_d  = ST_SETTLE;
                        flush_d  = '0;
                        settle_d = '0;
                    end else begin
                        flush_d = flush_q + FW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (apply) begin
                    settle_d = '0;
                end else if (dec_stb) begin
                    if (settle_q == SW'(N_STAGES - 1)) begin
                        state_d  = ST_RUN;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (apply) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!ctl.en) begin
            state_d  = ST_IDLE;
            flush_d  = '0;
            settle_d = '0;
        end
    end

    always_comb begin
        ratio_d = ratio_q;
        if (in_reset || apply) ratio_d = shadow_nxt;
        // The strobe that applies a new ratio carries a stale CIC result
        cap_d  = ctl.en && (state_q == ST_RUN) && dec_stb && !apply;
        data_d = capture ? ctl.cic_out : data_q;
        valid_d = valid_q;
        if (!ctl.en) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (valid_q && ctl.smp_ready) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_set ? 1'b1 : (ctl.ov_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flush_q  <= '0;
            settle_q <= '0;
            ratio_q  <= RW'(DEF_RATIO);
            shadow_q <= RW'(DEF_RATIO);
            cap_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            settle_q <= settle_d;
            ratio_q  <= ratio_d;
            shadow_q <= shadow_nxt;
            cap_q    <= cap_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign ctl.cic_rst   = in_reset;
    assign ctl.busy      = (state_q != ST_IDLE);
    assign ctl.pdm_ce    = pdm_ce;
    assign ctl.dec_stb   = dec_stb;
    assign ctl.smp_data  = data_q;
    assign ctl.smp_valid = valid_q;
    assign ctl.overrun   = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_cic_ctrl.sv
`default_nettype none
// tb_cic_ctrl: randomized scenarios for cic_ctrl checked against an event-level reference model.
// Rev 1.0
module tb_cic_ctrl;
    localparam int CD  = 4;
    localparam int RW  = 8;
    localparam int OW  = 24;
    localparam int NS  = 3;
    localparam int FC  = 4;
    localparam int DEF = 64;
    localparam int FL  = FC * CD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cic_ctrl_if #(.RW(RW), .OW(OW)) bus ();

    cic_ctrl #(
        .CLK_DIV   (CD),
        .RW        (RW),
        .DEF_RATIO (DEF),
        .N_STAGES  (NS),
        .FLUSH_CYC (FC),
        .OW        (OW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model: session time, next strobe time, strobes left to discard.
    bit            m_busy, m_cap, m_valid, m_ovr;
    int            m_s, m_next, m_ratio, m_shadow, m_discard;
    logic [OW-1:0] m_data;
    bit            e_cic_rst, e_pdm, e_stb;

    function automatic void model_outputs();
        e_cic_rst = !m_busy || (m_s < FL);
        e_pdm     = m_busy && ((m_s % CD) == CD - 1);
        e_stb     = m_busy && (m_s >= FL) && (m_s == m_next);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_cap = 0; m_valid = 0; m_ovr = 0;
        m_s = 0; m_next = 0; m_ratio = DEF; m_shadow = DEF; m_discard = 0;
        m_data = '0;
        model_outputs();
    endfunction

    function automatic void model_adv(input bit en, input bit ld, input int rin, input bit rdy,
                                      input bit clr, input logic [OW-1:0] cout);
        int sh;
        bit cap_now, set_ovr;
        sh      = ld ? ((rin < 2) ? 2 : rin) : m_shadow;
        cap_now = m_cap && en;
        set_ovr = cap_now && m_valid && !rdy;
        if (!en) m_valid = 0;
        else if (cap_now) begin m_valid = 1; m_data = cout; end
        else if (m_valid && rdy) m_valid = 0;
        m_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_cap = 0;
        if (!m_busy) begin
            m_ratio = sh;
            if (en) begin m_busy = 1; m_s = 0; end
        end else begin
            if (m_s < FL) begin
                m_ratio = sh;
                if (m_s == FL - 1) begin m_next = FL + sh * CD - 1; m_discard = NS; end
            end else if (e_stb) begin
                if (sh != m_ratio) begin m_ratio = sh; m_discard = NS; end
                else if (m_discard > 0) m_discard--;
                else m_cap = 1;
                m_next = m_s + m_ratio * CD;
            end
            m_s++;
            if (!en) begin m_busy = 0; m_cap = 0; end
        end
        m_shadow = sh;
        model_outputs();
    endfunction

    function automatic logic [OW+5:0] obs_vec();
        return {bus.busy, bus.cic_rst, bus.pdm_ce, bus.dec_stb, bus.smp_valid, bus.overrun, bus.smp_data};
    endfunction

    function automatic logic [OW+5:0] exp_vec();
        return {m_busy, e_cic_rst, e_pdm, e_stb, m_valid, m_ovr, m_data};
    endfunction

    task automatic step();
        bit l_en, l_ld, l_rdy, l_clr;
        int l_rin;
        logic [OW-1:0] l_cout;
        l_en = bus.en; l_ld = bus.ratio_ld; l_rdy = bus.smp_ready; l_clr = bus.ov_clr;
        l_rin = int'(bus.ratio_in); l_cout = bus.cic_out;
        @(posedge clk);
        #1;
        cyc++;
        model_adv(l_en, l_ld, l_rin, l_rdy, l_clr, l_cout);
        bus.ratio_ld = 1'b0;
        bus.ov_clr   = 1'b0;
        bus.cic_out  = OW'($urandom);
    endtask

    task automatic test_reset();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.cic_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cic_rst got %b want 1", bus.cic_rst); end
        n_tests++; if (bus.pdm_ce !== 1'b0) begin n_fail++; $display("FAIL reset_pdm_ce got %b want 0", bus.pdm_ce); end
        n_tests++; if (bus.dec_stb !== 1'b0) begin n_fail++; $display("FAIL reset_dec_stb got %b want 0", bus.dec_stb); end
        n_tests++; if (bus.smp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.smp_valid); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        n_tests++; if (bus.smp_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.smp_data); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_startup();
        int first_valid, rst_cycles;
        first_valid = -1; rst_cycles = 0;
        bus.ratio_in = 8'd8; bus.ratio_ld = 1'b1; bus.smp_ready = 1'b1;
        step();
        bus.en = 1'b1;
        for (int i = 0; i < FL + 32 * CD * 6 / 4 + 64; i++) begin
            step();
            if (bus.cic_rst) rst_cycles++;
            if (bus.smp_valid && first_valid < 0) first_valid = i;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL startup cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (rst_cycles != FL) begin n_fail++; $display("FAIL startup_flush_len got %0d want %0d", rst_cycles, FL); end
        n_tests++;
        if (first_valid != FL + 4 * 8 * CD + 1) begin
            n_fail++; $display("FAIL startup_first_valid got %0d want %0d", first_valid, FL + 4 * 8 * CD + 1);
        end
    endtask

    task automatic test_overrun();
        bus.smp_ready = 1'b0;
        for (int i = 0; i < 2 * 32 + 4; i++) begin
            step();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL overrun cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", bus.overrun); end
        bus.ov_clr = 1'b1; bus.smp_ready = 1'b1;
        step();
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", bus.overrun); end
        for (int i = 0; i < 300; i++) begin
            bus.smp_ready = 1'($urandom_range(1));
            bus.ov_clr    = ($urandom_range(7) == 0);
            step();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL handshake cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ratio_period(input int rin, input int want_ratio, input int ncyc, input string nm);
        int stb_q[$];
        bus.smp_ready = 1'b1;
        for (int i = 0; i < 1 + int'($urandom_range(20)); i++) step();
        bus.ratio_in = RW'(rin); bus.ratio_ld = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (bus.dec_stb) stb_q.push_back(cyc);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL %s cyc %0d got %h want %h", nm, cyc, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (stb_q.size() < 3) begin
            n_fail++; $display("FAIL %s_strobes got %0d want >=3", nm, stb_q.size());
        end else if (stb_q[2] - stb_q[1] != want_ratio * CD) begin
            n_fail++; $display("FAIL %s_period got %0d want %0d", nm, stb_q[2] - stb_q[1], want_ratio * CD);
        end
    endtask

    task automatic test_coincident_ld();
        int k, t0, t1;
        k = 0; t1 = -1;
        while (!e_stb && k < 300) begin
            step(); k++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL coincident_wait cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (!e_stb) begin
            n_fail++; $display("FAIL coincident_timeout got %0d cycles want strobe", k);
        end else begin
            t0 = cyc;
            bus.ratio_in = 8'd5; bus.ratio_ld = 1'b1;
            for (int i = 0; i < 5 * CD * 6; i++) begin
                step();
                if (bus.dec_stb && t1 < 0) t1 = cyc;
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL coincident cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
                end
            end
            n_tests++;
            if (t1 - t0 != 5 * CD) begin n_fail++; $display("FAIL coincident_gap got %0d want %0d", t1 - t0, 5 * CD); end
        end
    endtask

    task automatic test_disable();
        int k;
        logic [OW-1:0] held;
        bit ovr_held;
        k = 0;
        bus.smp_ready = 1'b0;
        while (!(m_valid && m_busy) && k < 500) begin
            step(); k++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL disable_wait cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        held = m_data; ovr_held = m_ovr;
        bus.en = 1'b0;
        step();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL disable_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.smp_valid !== 1'b0) begin n_fail++; $display("FAIL disable_valid got %b want 0", bus.smp_valid); end
        n_tests++; if (bus.cic_rst !== 1'b1) begin n_fail++; $display("FAIL disable_cic_rst got %b want 1", bus.cic_rst); end
        n_tests++; if (bus.pdm_ce !== 1'b0) begin n_fail++; $display("FAIL disable_pdm_ce got %b want 0", bus.pdm_ce); end
        n_tests++; if (bus.smp_data !== held) begin n_fail++; $display("FAIL disable_data got %h want %h", bus.smp_data, held); end
        n_tests++; if (bus.overrun !== ovr_held) begin n_fail++; $display("FAIL disable_ovr got %b want %b", bus.overrun, ovr_held); end
    endtask

    task automatic test_random();
        bus.en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.en        = ($urandom_range(299) != 0);
            bus.smp_ready = ($urandom_range(3) != 0);
            bus.ov_clr    = ($urandom_range(15) == 0);
            if ($urandom_range(199) == 0) begin
                bus.ratio_in = RW'($urandom_range(12)); bus.ratio_ld = 1'b1;
            end
            step();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int first_stb;
        first_stb = -1;
        bus.en = 1'b1; bus.smp_ready = 1'b1;
        for (int i = 0; i < 120; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {OW{1'b0}}}) begin
            n_fail++; $display("FAIL async_reset got %h want %h", obs_vec(), {1'b0, 1'b1, 4'b0, {OW{1'b0}}});
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < FL + DEF * CD + 8; i++) begin
            step();
            if (bus.dec_stb && first_stb < 0) first_stb = i;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL post_reset cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (first_stb != FL + DEF * CD - 1) begin
            n_fail++; $display("FAIL post_reset_first_stb got %0d want %0d", first_stb, FL + DEF * CD - 1);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        bus.en = 1'b0; bus.ratio_in = '0; bus.ratio_ld = 1'b0;
        bus.cic_out = '0; bus.smp_ready = 1'b0; bus.ov_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #6;
        rst_n = 1'b1;
        test_reset();
        test_startup();
        test_overrun();
        test_ratio_period(16, 16, 64 * 6, "ratio16");
        test_ratio_period(int'($urandom_range(1)), 2, 64 + 8 * 12, "clamp");
        test_coincident_ld();
        test_disable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
